uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/stop framing, LSB first, frame error on low stop bit.
// Define UART_RX_PARITY_EN to receive one even-parity bit after the data and expose parity_err.
module uart_rx #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic                 rx_meta_q;
  logic                 rx_s_q;
  logic                 rx_d_q;
  logic                 start_edge;
  state_t               state_q;
  logic [TW-1:0]        tick_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_done_q;
  logic                 frame_err_q;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit_q;
  logic                 parity_err_q;
`endif

  // Synchronizer idles high so reset never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
    end
  end

  assign start_edge = rx_d_q & ~rx_s_q;
  assign shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            state_q <= START;
            tick_q  <= '0;
          end
        end
        START: begin
          if (baud_tick) begin
            if (tick_q == TICK_MID) begin
              // A line back high at mid start bit was only a glitch.
              state_q <= rx_s_q ? IDLE : DATA;
              tick_q  <= '0;
              bit_q   <= '0;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (tick_q == TICK_LAST) begin
              tick_q  <= '0;
              shift_q <= shift_d;
              bit_q   <= bit_q + BW'(1);
              if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            if (tick_q == TICK_LAST) begin
              tick_q       <= '0;
              parity_bit_q <= rx_s_q;
              state_q      <= STOP;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (baud_tick) begin
            if (tick_q == TICK_LAST) begin
              tick_q       <= '0;
              rx_data_q    <= shift_q;
              rx_done_q    <= 1'b1;
              frame_err_q  <= ~rx_s_q;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= (^shift_q) ^ parity_bit_q;
`endif
              state_q      <= IDLE;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_done    = rx_done_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: vector table, hand-written corner sequences, and random frames
// compared against a frame-level model (data word, stop level, parity rule).
module tb_uart_rx;
  localparam int OS       = 8;
  localparam int DB       = 8;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLK  = OS * TICK_DIV;
  localparam int TIMEOUT  = 16 * BIT_CLK;
  localparam int N_RAND   = 30;

  logic          clk = 1'b0;
  logic          rst;
  logic          baud_tick;
  logic          rx;
  logic [DB-1:0] rx_data;
  logic          rx_done;
  logic          rx_busy;
  logic          frame_err;
  logic          perr_obs;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
  assign perr_obs = parity_err;
`else
  assign perr_obs = 1'b0;
`endif

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 baud_tick = 1'b1;
      @(posedge clk);
      #1 baud_tick = 1'b0;
    end
  end

  typedef struct {
    logic [DB-1:0] data;
    logic          ferr;
    logic          perr;
    logic          busy;
  } obs_t;

  typedef struct {
    logic [DB-1:0] data;
    logic          ferr;
    logic          perr;
  } frame_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  obs_t   obs_q[$];
  frame_t exp_q[$];
  logic   prev_done = 1'b0;
  int     double_hi = 0;
  int     done_total = 0;
  int     exp_frames = 0;
  int     n_pass = 0;
  int     n_total = 0;

  always @(negedge clk) begin
    prev_done <= rx_done;
    if (rx_done && prev_done) double_hi <= double_hi + 1;
    if (rx_done) begin
      done_total <= done_total + 1;
      obs_q.push_back('{rx_data, frame_err, perr_obs, rx_busy});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic hold(input logic v, input int clks);
    rx = v;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < DB; i++) hold(d[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
    hold(par, BIT_CLK);
`endif
    hold(stop, BIT_CLK);
  endtask

  task automatic expect_frame(input string nm, input logic [7:0] d, input logic fe, input logic pe);
    obs_t o;
    int   t;
    t = 0;
    exp_frames++;
    while (obs_q.size() == 0 && t < TIMEOUT) begin
      @(posedge clk);
      t++;
    end
    chk({nm, " rx_done seen"}, 32'(obs_q.size() != 0), 32'd1);
    if (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      chk({nm, " rx_data"}, 32'(o.data), 32'(d));
      chk({nm, " frame_err"}, 32'(o.ferr), 32'(fe));
      chk({nm, " rx_busy at done"}, 32'(o.busy), 32'd0);
`ifdef UART_RX_PARITY_EN
      chk({nm, " parity_err"}, 32'(o.perr), 32'(pe));
`endif
      $display("frame %s: data=0x%02h ferr=%0d perr=%0d (want 0x%02h/%0d/%0d)",
               nm, o.data, o.ferr, o.perr, d, fe, pe);
    end
  endtask

  vec_t       vt[8];
  logic [7:0] rd;
  logic       rs;
  logic       rp;
  int         rg;
  frame_t     ef;

  initial begin
    vt[0] = '{8'h55, 1'b1, 1'b0, BIT_CLK, 8'h55, 1'b0, 1'b0};
    vt[1] = '{8'hA3, 1'b0, 1'b0, BIT_CLK, 8'hA3, 1'b1, 1'b0};
    vt[2] = '{8'h5A, 1'b1, 1'b0, 0,       8'h5A, 1'b0, 1'b0};
    vt[3] = '{8'h00, 1'b1, 1'b0, 0,       8'h00, 1'b0, 1'b0};
    vt[4] = '{8'hFF, 1'b1, 1'b0, BIT_CLK, 8'hFF, 1'b0, 1'b0};
    vt[5] = '{8'h07, 1'b1, 1'b1, BIT_CLK, 8'h07, 1'b0, 1'b0};
    vt[6] = '{8'h07, 1'b1, 1'b0, BIT_CLK, 8'h07, 1'b0, 1'b1};
    vt[7] = '{8'hC4, 1'b1, 1'b1, BIT_CLK, 8'hC4, 1'b0, 1'b0};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rx_data", 32'(rx_data), 32'd0);
    chk("reset rx_done", 32'(rx_done), 32'd0);
    chk("reset frame_err", 32'(frame_err), 32'd0);
    chk("reset rx_busy", 32'(rx_busy), 32'd0);
    chk("reset parity_err", 32'(perr_obs), 32'd0);
    rst = 1'b0;
    hold(1'b1, 2 * BIT_CLK);

    for (int i = 0; i < 8; i++) begin
      send_frame(vt[i].data, vt[i].stop, vt[i].par);
      if (vt[i].gap > 0) hold(1'b1, vt[i].gap);
      expect_frame($sformatf("vec%0d", i), vt[i].exp_data, vt[i].exp_ferr, vt[i].exp_perr);
    end

    // Reset during data bit 4 of 0x3C: frame dropped, outputs cleared.
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) hold(rd_bit(8'h3C, i), BIT_CLK);
    hold(1'b1, 10);
    chk("busy before mid-frame reset", 32'(rx_busy), 32'd1);
    rst = 1'b1;
    hold(1'b1, 2);
    chk("mid-frame reset rx_data", 32'(rx_data), 32'd0);
    chk("mid-frame reset rx_busy", 32'(rx_busy), 32'd0);
    chk("mid-frame reset frame_err", 32'(frame_err), 32'd0);
    chk("mid-frame reset rx_done", 32'(rx_done), 32'd0);
    hold(1'b1, 3);
    rst = 1'b0;
    hold(1'b1, 3 * BIT_CLK);
    chk("no rx_done after reset", 32'(obs_q.size()), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0);
    hold(1'b1, BIT_CLK);
    expect_frame("after reset", 8'h81, 1'b0, 1'b0);

    // Two-tick glitch: START aborts, nothing delivered.
    hold(1'b0, 6);
    chk("glitch busy", 32'(rx_busy), 32'd1);
    hold(1'b0, 2 * TICK_DIV - 6);
    hold(1'b1, 2 * BIT_CLK);
    chk("glitch no rx_done", 32'(obs_q.size()), 32'd0);
    chk("glitch rx_data kept", 32'(rx_data), 32'h81);
    chk("glitch back idle", 32'(rx_busy), 32'd0);

    // Line stuck low: one all-zero frame with frame error, no retrigger.
    hold(1'b0, 14 * BIT_CLK);
    expect_frame("held low", 8'h00, 1'b1, 1'b0);
    chk("held low no retrigger", 32'(obs_q.size()), 32'd0);
    hold(1'b1, 2 * BIT_CLK);

    for (int k = 0; k < N_RAND; k++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      rp = 1'($urandom_range(0, 1));
      rg = rs ? int'($urandom_range(0, 40)) : int'($urandom_range(4, 40));
      exp_q.push_back('{rd, ~rs, (^rd) ^ rp});
      send_frame(rd, rs, rp);
      if (rg > 0) hold(1'b1, rg);
      ef = exp_q.pop_front();
      expect_frame($sformatf("rand%0d", k), ef.data, ef.ferr, ef.perr);
    end

    hold(1'b1, 2 * BIT_CLK);
    chk("rx_done pulse width", 32'(double_hi), 32'd0);
    chk("rx_done count", 32'(done_total), 32'(exp_frames));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  function automatic logic rd_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
